// File: rtl/qbert_input_pkg.sv
`default_nettype none
// ============================================================================
// qbert_input_pkg : dial FSM state type, hold thresholds and step sizes.
// Revision 1.0 - initial release
// ============================================================================
package qbert_input_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SLOW   = 2'd1,
      MEDIUM = 2'd2,
      FAST   = 2'd3
   } dial_state_t;

   localparam logic [6:0] HOLD_MED  = 7'd16;
   localparam logic [6:0] HOLD_FAST = 7'd64;

   localparam logic signed [8:0] STEP_SLOW = 9'sd1;
   localparam logic signed [8:0] STEP_MED  = 9'sd2;
   localparam logic signed [8:0] STEP_FAST = 9'sd4;

   function automatic dial_state_t state_for_count(input logic [6:0] cnt);
      if (cnt >= HOLD_FAST)
         return FAST;
      else if (cnt >= HOLD_MED)
         return MEDIUM;
      else if (cnt != 7'd0)
         return SLOW;
      else
         return IDLE;
   endfunction

   function automatic logic signed [8:0] step_for_state(input dial_state_t st);
      case (st)
         SLOW:    return STEP_SLOW;
         MEDIUM:  return STEP_MED;
         FAST:    return STEP_FAST;
         default: return 9'sd0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/toggle_sync.sv
`default_nettype none
// ============================================================================
// toggle_sync : two-flop synchroniser plus history flop; flags a new sample.
// Revision 1.0 - initial release
// ============================================================================
module toggle_sync (
   input  logic clk_sys,
   input  logic reset,
   input  logic tog_in,
   output logic event_out
);

   logic r_t1;
   logic r_t2;
   logic r_t3;

   // All three stages load the live input in reset so release cannot fake an edge.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_t1 <= tog_in;
         r_t2 <= tog_in;
         r_t3 <= tog_in;
      end else begin
         r_t1 <= tog_in;
         r_t2 <= r_t1;
         r_t3 <= r_t2;
      end
   end

   assign event_out = r_t2 ^ r_t3;

endmodule
`default_nettype wire

// File: rtl/dial_accum.sv
`default_nettype none
// ============================================================================
// dial_accum : merges spinner deltas and accelerated joystick steps into pos.
// Revision 1.0 - initial release
// ============================================================================
module dial_accum
   import qbert_input_pkg::*;
(
   input  logic       clk_sys,
   input  logic       reset,
   input  logic [8:0] spinner,
   input  logic       joy_left,
   input  logic       joy_right,
   input  logic       tick_en,
   input  logic [1:0] sens,
   input  logic       reverse,
   output logic [7:0] pos,
   output logic       step
);

   logic              w_spin_event;
   logic signed [7:0] w_delta;
   logic signed [7:0] w_shifted;
   logic signed [7:0] w_spin_scaled;
   logic signed [8:0] w_spin_term;

   dial_state_t       r_state;
   dial_state_t       w_state_nxt;
   logic [6:0]        r_hold;
   logic [6:0]        w_hold_nxt;
   logic [6:0]        w_hold_inc;
   logic              r_dir;
   logic              w_dir_nxt;
   logic              w_one_dir;
   logic              w_restart;
   logic signed [8:0] w_dig_term;

   logic signed [8:0] w_sum;
   logic signed [8:0] w_total;
   logic [7:0]        r_pos;
   logic              r_step;

   toggle_sync u_toggle_sync (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .tog_in    (spinner[8]),
      .event_out (w_spin_event)
   );

   // Spinner path: attenuate, but never let a real nudge vanish entirely.
   assign w_delta   = signed'(spinner[7:0]);
   assign w_shifted = w_delta >>> sens;

   always_comb begin
      w_spin_scaled = w_shifted;
      if ((w_delta != 8'sd0) && (w_shifted == 8'sd0))
         w_spin_scaled = w_delta[7] ? -8'sd1 : 8'sd1;
   end

   assign w_spin_term = w_spin_event ? {w_spin_scaled[7], w_spin_scaled} : 9'sd0;

   // Digital path: r_dir remembers which way the current hold is going (1 = right).
   assign w_one_dir  = joy_left ^ joy_right;
   assign w_restart  = (r_state == IDLE) || (joy_right != r_dir);
   assign w_hold_inc = (r_hold >= HOLD_FAST) ? HOLD_FAST : r_hold + 7'd1;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state <= IDLE;
         r_hold  <= 7'd0;
         r_dir   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_hold  <= w_hold_nxt;
         r_dir   <= w_dir_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold;
      w_dir_nxt   = r_dir;
      w_dig_term  = 9'sd0;
      if (!w_one_dir) begin
         w_state_nxt = IDLE;
         w_hold_nxt  = 7'd0;
      end else if (tick_en) begin
         if (w_restart) begin
            w_state_nxt = SLOW;
            w_hold_nxt  = 7'd1;
            w_dir_nxt   = joy_right;
         end else begin
            w_state_nxt = state_for_count(w_hold_inc);
            w_hold_nxt  = w_hold_inc;
         end
         w_dig_term = joy_right ? step_for_state(w_state_nxt)
                                : -step_for_state(w_state_nxt);
      end else if (w_restart) begin
         // Reversal without a tick drops the hold; the next tick starts afresh.
         w_state_nxt = IDLE;
         w_hold_nxt  = 7'd0;
      end
   end

   assign w_sum   = w_spin_term + w_dig_term;
   assign w_total = reverse ? -w_sum : w_sum;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_pos  <= 8'h00;
         r_step <= 1'b0;
      end else begin
         r_pos  <= r_pos + w_total[7:0];
         r_step <= (w_total != 9'sd0);
      end
   end

   assign pos  = r_pos;
   assign step = r_step;

endmodule
`default_nettype wire

// File: doc/dial_accum.md
DIAL_ACCUM -- requirements
Module: dial_accum

Interface
REQ-001 The block SHALL have one clock, clk_sys, and a synchronous, active-high reset, reset.
REQ-002 clk_sys  in  1  system clock (50 MHz).
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 spinner  in  9  [7:0] signed two's-complement delta; [8] toggles once per new sample; [7:0] stable for at least 4 clk_sys cycles around each toggle.
REQ-005 joy_left  in  1  digital dial-left request, level.
REQ-006 joy_right  in  1  digital dial-right request, level.
REQ-007 tick_en  in  1  one-cycle digital step strobe (about 1 kHz).
REQ-008 sens  in  2  spinner attenuation shift, 0..3.
REQ-009 reverse  in  1  negates all motion when 1.
REQ-010 pos  out  8  dial position, registered; drives the board's IPA1J2 input.
REQ-011 step  out  1  one-cycle pulse, registered, asserted in the cycle pos changes.

Function
REQ-012 The spinner[8] input SHALL pass through two sync flops (t1, t2) and one history flop (t3); a spinner event SHALL be defined as t2 != t3.
REQ-013 A toggle first sampled by t1 at edge N SHALL update pos at edge N+2, using the spinner[7:0] value present at that edge.
REQ-014 Scaled spinner delta SHALL be delta arithmetically shifted right by sens.
REQ-015 If delta is nonzero and the scaled result is 0, the scaled delta SHALL be +1 for a positive delta and -1 for a negative delta.
REQ-016 A delta of 0 SHALL produce no change and no step pulse.
REQ-017 The digital FSM SHALL have states IDLE, SLOW, MEDIUM and FAST, with a 7-bit hold counter that saturates at 64.
REQ-018 Exactly-one-direction condition: exactly one of joy_left or joy_right is high.
REQ-019 IDLE -> SLOW: on a tick_en cycle with the exactly-one-direction condition true; that same tick SHALL step pos, and the hold counter SHALL be set to 1.
REQ-020 On each tick_en cycle in SLOW, MEDIUM or FAST with the same direction held, the block SHALL step pos and increment the hold counter.
REQ-021 State SHALL be SLOW for hold counts 1..15, MEDIUM at 16..63 and FAST at 64.
REQ-022 Step magnitudes SHALL be 1 in SLOW, 2 in MEDIUM and 4 in FAST.
REQ-023 The step direction SHALL be right = +, left = -.
REQ-024 When neither or both directions are held, the FSM SHALL go to IDLE with the counter cleared on the next edge, independent of tick_en.
REQ-025 A direction reversal without release SHALL be treated as IDLE followed by a new press: SLOW, count 1, step in the new direction on that tick.
REQ-026 The hold counter SHALL change only on tick_en cycles, except when it is cleared.
REQ-027 When a spinner event and a digital step fall in the same cycle, both SHALL be summed into a 9-bit signed total.
REQ-028 If reverse is 1, the 9-bit signed total SHALL be negated.
REQ-029 pos SHALL update as pos + total modulo 256: 255 + 1 = 0 and 0 - 1 = 255, with no saturation.
REQ-030 step SHALL be 1 exactly in the cycle after an update with a nonzero total.
REQ-031 Changes to sens or reverse SHALL take effect on the next event and SHALL NOT alter pos by themselves.

Reset
REQ-032 On reset, pos = 0x00, step = 0, the FSM = IDLE and the hold counter = 0.
REQ-033 On reset, t1, t2 and t3 SHALL all load the current spinner[8], so that no spurious event follows reset release.
REQ-034 Reset asserted mid-hold or during a pending spinner event SHALL discard the pending motion.
REQ-035 After reset release, a still-held direction SHALL restart from IDLE on the next tick_en.

Structure
REQ-036 Package qbert_input_pkg SHALL hold the FSM state enum and the constants HOLD_MED = 16, HOLD_FAST = 64 and STEP_SLOW/MED/FAST = 1/2/4.
REQ-037 The toggle synchroniser and event detector SHALL be the single sub-module toggle_sync, with ports clk_sys, reset, tog_in and event_out.
REQ-038 The remaining logic (scaling, FSM, accumulator) SHALL be in dial_accum.

Verification
REQ-039 Spinner basic: reset, sens=0, spinner = {toggle, 8'h05} -> pos = 0x05 at the 3rd edge after the toggle, with a 1-cycle step pulse.
REQ-040 Attenuation and wrap: pos = 0xFE, sens=2, delta = +3 -> pos = 0xFF; then delta = +9 -> pos = 0x01; then delta = -128 with sens=3 -> pos = 0xF1.
REQ-041 Digital acceleration: joy_right held for 70 ticks from pos = 0 -> pos = 15*1 + 48*2 + 7*4 = 139 (0x8B); the FSM reaches FAST at tick 64 (the 64th tick, counting the IDLE->SLOW tick as tick 1).
REQ-042 Release and reversal: hold right 20 ticks, then switch to left without a gap -> the first left tick gives -1 and the state is SLOW; both held -> IDLE on the next edge with no step.
REQ-043 Simultaneous events: a spinner delta of -3 (sens=0) coinciding with a FAST right step (+4), reverse=1 -> pos decreases by 1.
REQ-044 Reset safety: spinner[8] = 1 during reset, then release -> pos stays 0x00 and step stays 0 for 10 cycles; reset applied mid-hold -> pos = 0 and the FSM = IDLE.
